// File: rtl/ticket_booking_engine.sv
// Seat-booking engine: per (class, date) seat-count table serving check, book and cancel
// requests over valid/ready request and response channels.
// Optional build macro TICKET_STATS_EN adds saturating booked/cancelled/rejected counters;
// without it the stat ports are tied to zero.
module ticket_booking_engine #(
    parameter int unsigned NUM_CLASSES    = 3,
    parameter int unsigned NUM_DATES      = 32,
    parameter int unsigned SEATS_PER_SLOT = 10,
    parameter int unsigned QTY_W          = 3,
    parameter int unsigned BASE_PRICE     = 100,
    parameter int unsigned PRICE_STEP     = 50,
    parameter int unsigned PRICE_W        = 16,
    localparam int unsigned CLASS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
    localparam int unsigned DATE_W  = (NUM_DATES > 1) ? $clog2(NUM_DATES) : 1,
    localparam int unsigned CNT_W   = $clog2(SEATS_PER_SLOT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [1:0]         req_op,
    input  logic [CLASS_W-1:0] req_class,
    input  logic [DATE_W-1:0]  req_date,
    input  logic [QTY_W-1:0]   req_qty,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [1:0]         rsp_status,
    output logic [PRICE_W-1:0] rsp_price,
    output logic [CNT_W-1:0]   rsp_seats_left,
    output logic [15:0]        stat_booked,
    output logic [15:0]        stat_cancelled,
    output logic [15:0]        stat_rejected
);

    localparam int unsigned NUM_SLOTS = NUM_CLASSES * NUM_DATES;
    localparam int unsigned SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    // Wide enough that neither count-qty nor count+qty wraps.
    localparam int unsigned ARITH_W   = ((CNT_W > QTY_W) ? CNT_W : QTY_W) + 1;

    localparam logic [1:0] OpCheck  = 2'b00;
    localparam logic [1:0] OpBook   = 2'b01;
    localparam logic [1:0] OpCancel = 2'b10;

    localparam logic [1:0] StsOk      = 2'd0;
    localparam logic [1:0] StsSoldOut = 2'd1;
    localparam logic [1:0] StsOverflw = 2'd2;
    localparam logic [1:0] StsBadReq  = 2'd3;

    typedef enum logic [1:0] {StIdle, StLookup, StCommit, StResp} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     seat_cnt_q [NUM_SLOTS];

    logic [1:0]           op_q;
    logic [CLASS_W-1:0]   class_q;
    logic [DATE_W-1:0]    date_q;
    logic [QTY_W-1:0]     qty_q;
    logic                 bad_q;
    logic [CNT_W-1:0]     count_q;
    logic [PRICE_W-1:0]   unit_q;
    logic [SLOT_W-1:0]    slot_q;

    logic                 bad_d;
    logic [SLOT_W-1:0]    slot_d;
    logic [PRICE_W-1:0]   unit_d;

    logic [ARITH_W-1:0]   diff, sum;
    logic [PRICE_W-1:0]   total;
    logic [1:0]           status_d;
    logic [PRICE_W-1:0]   price_d;
    logic [CNT_W-1:0]     seats_d;
    logic                 wr_en;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) state_d = StLookup;
            end
            StLookup: state_d = StCommit;
            StCommit: state_d = StResp;
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Lookup stage: range check, slot address and unit price.
    always_comb begin
        bad_d = (32'(class_q) >= NUM_CLASSES) || (32'(date_q) >= NUM_DATES) ||
                (op_q == 2'b11) || ((op_q != OpCheck) && (qty_q == '0));
        // Out-of-range requests never touch the table; park the address at 0.
        slot_d = bad_d ? '0 : SLOT_W'(SLOT_W'(class_q) * SLOT_W'(NUM_DATES) + SLOT_W'(date_q));
        unit_d = PRICE_W'(32'(BASE_PRICE) + 32'(class_q) * 32'(PRICE_STEP));
    end

    // Commit stage: outcome, response payload and table write value.
    always_comb begin
        diff     = ARITH_W'(count_q) - ARITH_W'(qty_q);
        sum      = ARITH_W'(count_q) + ARITH_W'(qty_q);
        total    = unit_q * PRICE_W'(qty_q);
        status_d = StsOk;
        price_d  = '0;
        seats_d  = count_q;
        wr_en    = 1'b0;
        if (bad_q) begin
            status_d = StsBadReq;
            seats_d  = '0;
        end else if (op_q == OpCheck) begin
            price_d = unit_q;
        end else if (op_q == OpBook) begin
            // Borrow out of the MSB means qty exceeds the remaining count.
            if (diff[ARITH_W-1]) begin
                status_d = StsSoldOut;
            end else begin
                price_d = total;
                seats_d = diff[CNT_W-1:0];
                wr_en   = 1'b1;
            end
        end else begin
            if (sum > ARITH_W'(SEATS_PER_SLOT)) begin
                status_d = StsOverflw;
            end else begin
                price_d = total;
                seats_d = sum[CNT_W-1:0];
                wr_en   = 1'b1;
            end
        end
    end

    // Request capture, lookup registers, table and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q           <= '0;
            class_q        <= '0;
            date_q         <= '0;
            qty_q          <= '0;
            bad_q          <= 1'b0;
            count_q        <= '0;
            unit_q         <= '0;
            slot_q         <= '0;
            rsp_status     <= '0;
            rsp_price      <= '0;
            rsp_seats_left <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) seat_cnt_q[i] <= CNT_W'(SEATS_PER_SLOT);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        op_q    <= req_op;
                        class_q <= req_class;
                        date_q  <= req_date;
                        qty_q   <= req_qty;
                    end
                end
                StLookup: begin
                    bad_q   <= bad_d;
                    slot_q  <= slot_d;
                    count_q <= seat_cnt_q[slot_d];
                    unit_q  <= unit_d;
                end
                StCommit: begin
                    rsp_status     <= status_d;
                    rsp_price      <= price_d;
                    rsp_seats_left <= seats_d;
                    if (wr_en) seat_cnt_q[slot_q] <= seats_d;
                end
                default: ;
            endcase
        end
    end

`ifdef TICKET_STATS_EN
    logic [15:0] booked_q, cancelled_q, rejected_q;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Saturating usage counters, updated as each response is committed.
    always_ff @(posedge clk) begin
        if (rst) begin
            booked_q    <= '0;
            cancelled_q <= '0;
            rejected_q  <= '0;
        end else if (state_q == StCommit) begin
            if (status_d != StsOk)    rejected_q  <= sat_add(rejected_q, 16'd1);
            else if (op_q == OpBook)   booked_q    <= sat_add(booked_q, 16'(qty_q));
            else if (op_q == OpCancel) cancelled_q <= sat_add(cancelled_q, 16'(qty_q));
        end
    end

    assign stat_booked    = booked_q;
    assign stat_cancelled = cancelled_q;
    assign stat_rejected  = rejected_q;
`else
    assign stat_booked    = '0;
    assign stat_cancelled = '0;
    assign stat_rejected  = '0;
`endif

endmodule

// File: tb/tb_ticket_booking_engine.sv
// Scoreboard bench for ticket_booking_engine: the driver queues hand-computed responses,
// the monitor pops and compares at every response handshake.
module tb_ticket_booking_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [1:0]  req_class = '0;
    logic [4:0]  req_date = '0;
    logic [2:0]  req_qty = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [1:0]  rsp_status;
    logic [15:0] rsp_price;
    logic [3:0]  rsp_seats_left;
    logic [15:0] stat_booked, stat_cancelled, stat_rejected;

    typedef struct {
        logic [1:0]  st;
        logic [15:0] price;
        logic [3:0]  seats;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    ticket_booking_engine dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_class      (req_class),
        .req_date       (req_date),
        .req_qty        (req_qty),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_status     (rsp_status),
        .rsp_price      (rsp_price),
        .rsp_seats_left (rsp_seats_left),
        .stat_booked    (stat_booked),
        .stat_cancelled (stat_cancelled),
        .stat_rejected  (stat_rejected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s got timeout want event (t=%0t)", name, $time);
    endtask

    // Monitor: compare every handshaked response against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp got status %0d want no response", rsp_status);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_status", 32'(rsp_status), 32'(e.st));
                chk("rsp_price", 32'(rsp_price), 32'(e.price));
                chk("rsp_seats_left", 32'(rsp_seats_left), 32'(e.seats));
            end
        end
    end

    task automatic drive(input logic [1:0] op, input logic [1:0] cls, input logic [4:0] date,
                         input logic [2:0] qty);
        req_valid = 1'b1;
        req_op    = op;
        req_class = cls;
        req_date  = date;
        req_qty   = qty;
    endtask

    // Issue one request, verify handshake latency, wait for its response to be consumed.
    task automatic send(input logic [1:0] op, input logic [1:0] cls, input logic [4:0] date,
                        input logic [2:0] qty, input logic [1:0] st, input logic [15:0] price,
                        input logic [3:0] seats);
        exp_t e;
        int   n;
        e.st = st; e.price = price; e.seats = seats;
        sb.push_back(e);
        @(negedge clk);
        drive(op, cls, date, qty);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            fail("accept");
            req_valid = 1'b0;
            sb.delete();
            return;
        end
        @(posedge clk); #1 req_valid = 1'b0;
        chk("req_ready_after_e0", 32'(req_ready), 0);
        chk("rsp_valid_after_e0", 32'(rsp_valid), 0);
        @(posedge clk); #1 chk("rsp_valid_after_e1", 32'(rsp_valid), 0);
        @(posedge clk); #1 chk("rsp_valid_after_e2", 32'(rsp_valid), 1);
        n = 0;
        while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin fail("response"); sb.delete(); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 1);
        chk("reset_rsp_valid", 32'(rsp_valid), 0);
        chk("reset_rsp_status", 32'(rsp_status), 0);
        chk("reset_rsp_price", 32'(rsp_price), 0);
        chk("reset_rsp_seats", 32'(rsp_seats_left), 0);

        // op, class, date, qty -> status, price, seats_left
        send(2'b00, 2'd1, 5'd5,  3'd0, 2'd0, 16'd150,  4'd10);
        send(2'b01, 2'd2, 5'd31, 3'd4, 2'd0, 16'd800,  4'd6);
        send(2'b01, 2'd2, 5'd31, 3'd7, 2'd1, 16'd0,    4'd6);
        send(2'b01, 2'd2, 5'd31, 3'd6, 2'd0, 16'd1200, 4'd0);
        send(2'b01, 2'd2, 5'd31, 3'd1, 2'd1, 16'd0,    4'd0);
        send(2'b10, 2'd0, 5'd0,  3'd1, 2'd2, 16'd0,    4'd10);
        send(2'b01, 2'd0, 5'd0,  3'd3, 2'd0, 16'd300,  4'd7);
        send(2'b10, 2'd0, 5'd0,  3'd3, 2'd0, 16'd300,  4'd10);
        send(2'b01, 2'd3, 5'd2,  3'd1, 2'd3, 16'd0,    4'd0);
        send(2'b11, 2'd0, 5'd0,  3'd1, 2'd3, 16'd0,    4'd0);
        send(2'b01, 2'd0, 5'd0,  3'd0, 2'd3, 16'd0,    4'd0);
        send(2'b00, 2'd0, 5'd0,  3'd0, 2'd0, 16'd100,  4'd10);
        send(2'b00, 2'd2, 5'd31, 3'd0, 2'd0, 16'd200,  4'd0);

        // Back-pressure: response must hold while a second request waits.
        rsp_ready = 1'b0;
        e.st = 2'd0; e.price = 16'd300; e.seats = 4'd8;
        sb.push_back(e);
        @(negedge clk);
        drive(2'b01, 2'd1, 5'd10, 3'd2);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) fail("hold_accept");
        @(posedge clk); #1;
        drive(2'b00, 2'd1, 5'd10, 3'd0);
        e.st = 2'd0; e.price = 16'd150; e.seats = 4'd8;
        sb.push_back(e);
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
        if (!rsp_valid) fail("hold_rsp_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 1);
            chk("hold_rsp_status", 32'(rsp_status), 0);
            chk("hold_rsp_price", 32'(rsp_price), 300);
            chk("hold_rsp_seats", 32'(rsp_seats_left), 8);
            chk("hold_req_ready", 32'(req_ready), 0);
        end
        @(posedge clk); #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("hs_req_ready_low", 32'(req_ready), 0);
        @(negedge clk);
        chk("hs_req_ready_rise", 32'(req_ready), 1);
        @(posedge clk); #1 req_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 50) begin @(negedge clk); n++; end
        if (sb.size() != 0) begin fail("hold_second_rsp"); sb.delete(); end

        send(2'b10, 2'd1, 5'd10, 3'd7, 2'd2, 16'd0, 4'd8);

`ifdef TICKET_STATS_EN
        chk("stat_booked", 32'(stat_booked), 15);
        chk("stat_cancelled", 32'(stat_cancelled), 3);
        chk("stat_rejected", 32'(stat_rejected), 7);
`else
        chk("stat_booked_tied", 32'(stat_booked), 0);
        chk("stat_cancelled_tied", 32'(stat_cancelled), 0);
        chk("stat_rejected_tied", 32'(stat_rejected), 0);
`endif

        // Reset while the book sits in COMMIT: no response, no table update.
        @(negedge clk);
        drive(2'b01, 2'd0, 5'd7, 3'd2);
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) fail("abort_accept");
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_rsp_valid", 32'(rsp_valid), 0);
        chk("abort_req_ready", 32'(req_ready), 1);
        chk("abort_stat_booked", 32'(stat_booked), 0);
        chk("abort_stat_rejected", 32'(stat_rejected), 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 0);
        end
        send(2'b00, 2'd0, 5'd7,  3'd0, 2'd0, 16'd100, 4'd10);
        send(2'b00, 2'd2, 5'd31, 3'd0, 2'd0, 16'd200, 4'd10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ticket_booking_engine.md
Name: ticket_booking_engine

Overview:
Parametrised successor to the single-seat booking FSM. It keeps a seat-count table per (class, date) slot and serves check, book and cancel requests over a valid/ready request channel and a valid/ready response channel. It adds multi-seat quantities, capacity-bounded cancels, range checking, status codes and total pricing. It sits between the front-end command decoder and the display/payment logic.

Parameters:
NUM_CLASSES, 3, number of seat classes; CLASS_W = max(1,$clog2(NUM_CLASSES))
NUM_DATES, 32, number of travel dates; DATE_W = max(1,$clog2(NUM_DATES))
SEATS_PER_SLOT, 10, capacity per slot and reset value; CNT_W = $clog2(SEATS_PER_SLOT+1)
QTY_W, 3, width of the seat-quantity field
BASE_PRICE, 100, unit price of class 0
PRICE_STEP, 50, unit-price increment per class index
PRICE_W, 16, width of the price output

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  engine accepts a request (high only in IDLE)
req_op  in  2  00 check, 01 book, 10 cancel, 11 reserved
req_class  in  CLASS_W  seat class
req_date  in  DATE_W  travel date
req_qty  in  QTY_W  seats to book or cancel (ignored for check)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes the response
rsp_status  out  2  0 OK, 1 SOLD_OUT, 2 OVERFLOW, 3 BAD_REQ
rsp_price  out  PRICE_W  check: unit price; book: total charged; cancel: total refunded; 0 on non-OK
rsp_seats_left  out  CNT_W  slot count after the operation (0 on BAD_REQ)
stat_booked  out  16  seats booked since reset (feature only)
stat_cancelled  out  16  seats cancelled since reset (feature only)
stat_rejected  out  16  non-OK responses since reset (feature only)

Behaviour:
- Reset (rst=1 at a clk edge): FSM goes to IDLE; every slot is set to SEATS_PER_SLOT; req_ready=1 after reset; rsp_valid=0, rsp_status=0, rsp_price=0, rsp_seats_left=0; stats=0. Reset mid-operation aborts the request with no response and no table update.
- FSM states: IDLE, LOOKUP, COMMIT, RESP.
  - IDLE -> LOOKUP on req_valid&req_ready (edge E0); op, class, date and qty are registered.
  - LOOKUP -> COMMIT at E1: range check, slot read, unit price = BASE_PRICE + class*PRICE_STEP.
  - COMMIT -> RESP at E2: table write and response registers loaded; rsp_valid=1 from E2.
  - RESP holds all rsp_* stable while rsp_ready=0. On rsp_valid&rsp_ready go to IDLE; req_ready rises the following cycle.
  - Minimum of 4 cycles per request. req_valid is ignored outside IDLE.
- Validation, checked in this priority order:
  1. class>=NUM_CLASSES, date>=NUM_DATES, op=11, or qty=0 on book/cancel -> BAD_REQ.
  2. Book with qty > count -> SOLD_OUT. No partial booking; table unchanged; rsp_seats_left = current count.
  3. Cancel with count+qty > SEATS_PER_SLOT -> OVERFLOW; table unchanged.
  4. Otherwise OK.
- Arithmetic: the book write is count-qty and the cancel write is count+qty, both computed at CNT_W+1 bits before range checks.
  - Total price = unit*qty, truncated to PRICE_W.
  - Check returns OK with the unit price and the current count.
- Count reaching exactly 0 or exactly SEATS_PER_SLOT is legal. A later book on 0 yields SOLD_OUT; a later cancel at capacity yields OVERFLOW.
- Exactly one table write per accepted request, only on OK book or cancel.

Optional Feature:
TICKET_STATS_EN
- Defined: stat_booked increments by qty on each OK book and stat_cancelled by qty on each OK cancel, updated at E2. stat_rejected increments by 1 on every non-OK response. All three saturate at 16'hFFFF and clear on rst.
- Undefined: the stat ports are tied to 0 and no counter logic is built.

Test Plan:
- Reset then check class 1, date 5 -> OK, price 150, seats_left 10; rsp_valid 2 edges after acceptance; req_ready low until the handshake.
- Book class 2, date 31, qty 4 -> OK, price 800, seats_left 6. Then book qty 7 -> SOLD_OUT, price 0, seats_left 6. Then book qty 6 -> OK, seats_left 0.
- Cancel class 0, date 0, qty 1 on a fresh slot -> OVERFLOW, seats_left 10. Book qty 3 then cancel qty 3 -> OK, refund 300, seats_left 10.
- Class 3, date 2, qty 1 -> BAD_REQ. op=11 -> BAD_REQ. Book qty 0 -> BAD_REQ. Table unchanged each time; stat_rejected=3 with TICKET_STATS_EN.
- Hold rsp_ready=0 for 5 cycles with req_valid=1 -> response stable, req_ready=0, second request accepted only after the handshake.
- Assert rst while in COMMIT after a book of qty 2 -> no response; a following check shows seats_left 10.
